// File: rtl/id_ex_latch_dumper_pkg.sv
// Shared debug-dump definitions: frame geometry, ctrl64 field map and dumper FSM states.
// The host-side decoder and the other pipeline-latch dumpers rely on the same constants.
package id_ex_latch_dumper_pkg;

    localparam int BYTE_W    = 8;
    localparam int CTRL_BITS = 64;

    localparam int REG_IDX_W = 5;
    localparam int OFFS_W    = 26;
    localparam int FLAGS_W   = 23;

    localparam int RD_MSB    = 63;
    localparam int RT_MSB    = 58;
    localparam int RS_MSB    = 53;
    localparam int OFFS_MSB  = 48;
    localparam int FLAGS_MSB = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    function automatic int frame_bits(input int nbits);
        return 4 * nbits + CTRL_BITS;
    endfunction

    function automatic int frame_bytes(input int nbits);
        return frame_bits(nbits) / BYTE_W;
    endfunction

    // Places each ctrl64 field at its published offset so the decoder map stays authoritative.
    function automatic logic [CTRL_BITS-1:0] pack_ctrl64(
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rt,
        input logic [REG_IDX_W-1:0] rs,
        input logic [OFFS_W-1:0]    offs,
        input logic [FLAGS_W-1:0]   flags
    );
        logic [CTRL_BITS-1:0] c;
        c = {CTRL_BITS{1'b0}};
        c[RD_MSB    -: REG_IDX_W] = rd;
        c[RT_MSB    -: REG_IDX_W] = rt;
        c[RS_MSB    -: REG_IDX_W] = rs;
        c[OFFS_MSB  -: OFFS_W]    = offs;
        c[FLAGS_MSB -: FLAGS_W]   = flags;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_latch_dumper_if.sv
// Byte-wide valid/ready link from a latch dumper to the debug UART transmitter.
interface id_ex_latch_dumper_if;
    import id_ex_latch_dumper_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/id_ex_latch_dumper.sv
// Snapshots the ID/EX latch on a debug start pulse and streams it MSB-first as bytes.
// Read-only with respect to the pipeline.
module id_ex_latch_dumper
    import id_ex_latch_dumper_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,

    input  logic [NBITS-1:0]     i_pc,
    input  logic [NBITS-1:0]     i_ALU_src_A,
    input  logic [NBITS-1:0]     i_ALU_src_B,
    input  logic [NBITS-1:0]     i_AGU_src_addr,

    input  logic [REG_IDX_W-1:0] i_rd,
    input  logic [REG_IDX_W-1:0] i_rt,
    input  logic [REG_IDX_W-1:0] i_rs,
    input  logic [OFFS_W-1:0]    i_addr_offset,

    input  logic                 i_flg_equal,
    input  logic                 i_flg_unsign,
    input  logic                 i_flg_branch,
    input  logic                 i_flg_jump,
    input  logic                 i_flg_reg_wr_en,
    input  logic                 i_flg_mem_wr_en,
    input  logic                 i_flg_wb_src,
    input  logic                 i_flg_ALU_src_B,
    input  logic                 i_flg_mem_op,
    input  logic                 i_flg_halt,
    input  logic [1:0]           i_flg_mem_size,
    input  logic [1:0]           i_ALU_dst,
    input  logic [1:0]           i_flg_ALU_src_A,
    input  logic [3:0]           i_ALU_opcode,
    input  logic [2:0]           i_AGU_opcode,

    id_ex_latch_dumper_if.master tx,

    output logic                 o_busy,
    output logic                 o_done
);

    localparam int FRAME_BITS  = frame_bits(NBITS);
    localparam int FRAME_BYTES = frame_bytes(NBITS);
    localparam int CNT_W       = $clog2(FRAME_BYTES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    dump_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [FLAGS_W-1:0]      flags_s;
    logic [CTRL_BITS-1:0]    ctrl_s;
    logic [FRAME_BITS-1:0]   frame_s;
    logic                    xfer_s;

    // Low 23 bits of ctrl64, halt ending up at bit 0.
    assign flags_s = {i_flg_equal, i_flg_mem_size, i_flg_unsign, i_ALU_dst,
                      i_ALU_opcode, i_AGU_opcode, i_flg_branch, i_flg_jump,
                      i_flg_reg_wr_en, i_flg_mem_wr_en, i_flg_wb_src,
                      i_flg_ALU_src_A, i_flg_ALU_src_B, i_flg_mem_op, i_flg_halt};

    assign ctrl_s  = pack_ctrl64(i_rd, i_rt, i_rs, i_addr_offset, flags_s);
    assign frame_s = {i_pc, i_ALU_src_A, i_ALU_src_B, i_AGU_src_addr, ctrl_s};

    assign xfer_s  = valid_q & tx.tx_ready;

    // Next-state, shift and count decode for the dump sequencer.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    shreg_d = frame_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (xfer_s) begin
                    shreg_d = {shreg_q[FRAME_BITS-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs follow the upcoming state so they leave the block registered.
    always_comb begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_d)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            SEND: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
            DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shreg_q <= {FRAME_BITS{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx.tx_data  = shreg_q[FRAME_BITS-1 -: BYTE_W];
    assign tx.tx_valid = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_id_ex_latch_dumper.sv
// Self-checking bench for id_ex_latch_dumper: byte-queue reference model plus directed scenarios.
module tb_id_ex_latch_dumper;
    import id_ex_latch_dumper_pkg::*;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, ready;
    logic [31:0] pc, src_a, src_b, agu;
    logic [4:0]  rd, rt, rs;
    logic [25:0] offs;
    logic        f_equal, f_unsign, f_branch, f_jump, f_reg_wr, f_mem_wr;
    logic        f_wb_src, f_src_b, f_mem_op, f_halt;
    logic [1:0]  f_mem_size, alu_dst, f_src_a;
    logic [3:0]  alu_op;
    logic [2:0]  agu_op;
    logic        busy, done;

    id_ex_latch_dumper_if tx_if ();
    assign tx_if.tx_ready = ready;

    id_ex_latch_dumper #(.NBITS(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_pc(pc), .i_ALU_src_A(src_a), .i_ALU_src_B(src_b), .i_AGU_src_addr(agu),
        .i_rd(rd), .i_rt(rt), .i_rs(rs), .i_addr_offset(offs),
        .i_flg_equal(f_equal), .i_flg_unsign(f_unsign), .i_flg_branch(f_branch),
        .i_flg_jump(f_jump), .i_flg_reg_wr_en(f_reg_wr), .i_flg_mem_wr_en(f_mem_wr),
        .i_flg_wb_src(f_wb_src), .i_flg_ALU_src_B(f_src_b), .i_flg_mem_op(f_mem_op),
        .i_flg_halt(f_halt), .i_flg_mem_size(f_mem_size), .i_ALU_dst(alu_dst),
        .i_flg_ALU_src_A(f_src_a), .i_ALU_opcode(alu_op), .i_AGU_opcode(agu_op),
        .tx(tx_if.master), .o_busy(busy), .o_done(done)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bq_t rx_log;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] app(input logic [191:0] acc, input int w, input logic [31:0] v);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (acc << w) | 192'(64'(v) & mask);
    endfunction

    // Frame as a plain MSB-first accumulation of the fields, cut into bytes.
    function automatic bq_t make_frame();
        logic [191:0] acc;
        bq_t r;
        acc = '0;
        acc = app(acc, 32, pc);       acc = app(acc, 32, src_a);
        acc = app(acc, 32, src_b);    acc = app(acc, 32, agu);
        acc = app(acc, 5, 32'(rd));   acc = app(acc, 5, 32'(rt));
        acc = app(acc, 5, 32'(rs));   acc = app(acc, 26, 32'(offs));
        acc = app(acc, 1, 32'(f_equal));  acc = app(acc, 2, 32'(f_mem_size));
        acc = app(acc, 1, 32'(f_unsign)); acc = app(acc, 2, 32'(alu_dst));
        acc = app(acc, 4, 32'(alu_op));   acc = app(acc, 3, 32'(agu_op));
        acc = app(acc, 1, 32'(f_branch)); acc = app(acc, 1, 32'(f_jump));
        acc = app(acc, 1, 32'(f_reg_wr)); acc = app(acc, 1, 32'(f_mem_wr));
        acc = app(acc, 1, 32'(f_wb_src)); acc = app(acc, 2, 32'(f_src_a));
        acc = app(acc, 1, 32'(f_src_b));  acc = app(acc, 1, 32'(f_mem_op));
        acc = app(acc, 1, 32'(f_halt));
        for (int i = 0; i < 24; i++) r.push_back(acc[191 - 8*i -: 8]);
        return r;
    endfunction

    // Reference model: bytes still owed, and whether a done pulse is due this cycle.
    bq_t mq;
    bit  m_done = 1'b0;
    bit  armed  = 1'b0;
    bit  ev, eb;
    logic [7:0] ed;

    always @(negedge clk) begin
        if (armed) begin
            ev = (mq.size() > 0);
            ed = ev ? mq[0] : 8'h00;
            eb = ev || m_done;
            chk("tx_valid", 32'(tx_if.tx_valid), 32'(ev));
            chk("tx_data", 32'(tx_if.tx_data), 32'(ed));
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(m_done));
            if (!rst) begin
                if (tx_if.tx_valid && ready) rx_log.push_back(tx_if.tx_data);
                if (done) done_cnt++;
            end
        end
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            m_done = 1'b0;
            if (ev && ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
            if (start && !eb) mq = make_frame();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        chk({nm, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_q(input string nm, input bq_t act, input bq_t exp);
        chk({nm, "_len"}, 32'(act.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), 32'(act[i]), 32'(exp[i]));
    endtask

    task automatic clear_flags();
        f_equal = 1'b0; f_unsign = 1'b0; f_branch = 1'b0; f_jump = 1'b0;
        f_reg_wr = 1'b0; f_mem_wr = 1'b0; f_wb_src = 1'b0; f_src_b = 1'b0;
        f_mem_op = 1'b0; f_halt = 1'b0; f_mem_size = 2'd0; alu_dst = 2'd0;
        f_src_a = 2'd0; alu_op = 4'd0; agu_op = 3'd0;
    endtask

    task automatic set_frame_a();
        pc = 32'h0000_0040; src_a = 32'h1111_1111; src_b = 32'h2222_2222; agu = 32'h3333_3333;
        rd = 5'd3; rt = 5'd2; rs = 5'd1; offs = 26'd0;
        clear_flags();
        f_halt = 1'b1;
    endtask

    task automatic set_frame_b();
        pc = 32'hDEAD_BEEF; src_a = 32'h0123_4567; src_b = 32'h89AB_CDEF; agu = 32'hCAFE_F00D;
        rd = 5'd31; rt = 5'd17; rs = 5'd9; offs = 26'h2AB_CDEF;
        f_equal = 1'b1; f_mem_size = 2'd2; f_unsign = 1'b1; alu_dst = 2'd1;
        alu_op = 4'hA; agu_op = 3'd5; f_branch = 1'b1; f_jump = 1'b0;
        f_reg_wr = 1'b1; f_mem_wr = 1'b0; f_wb_src = 1'b1; f_src_a = 2'd3;
        f_src_b = 1'b1; f_mem_op = 1'b0; f_halt = 1'b0;
    endtask

    task automatic set_frame_c();
        pc = 32'h5A5A_5A5A; src_a = 32'hA5A5_A5A5; src_b = 32'h0F0F_0F0F; agu = 32'hF0F0_F0F0;
        rd = 5'd12; rt = 5'd25; rs = 5'd30; offs = 26'h3FF_FFFF;
        f_equal = 1'b1; f_mem_size = 2'd3; f_unsign = 1'b1; alu_dst = 2'd3;
        alu_op = 4'hF; agu_op = 3'd7; f_branch = 1'b1; f_jump = 1'b1;
        f_reg_wr = 1'b1; f_mem_wr = 1'b1; f_wb_src = 1'b1; f_src_a = 2'd3;
        f_src_b = 1'b1; f_mem_op = 1'b1; f_halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        bq_t exp_a, exp_b, exp_c, exp_ac;
        int k;
        exp_a = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h11, 8'h11, 8'h11,
                  8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33,
                  8'h18, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

        rst = 1'b1; start = 1'b0; ready = 1'b1;
        set_frame_a();
        tick(); tick();
        rst = 1'b0;
        chk("reset_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("reset_data", 32'(tx_if.tx_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        compare_q("model_pin_a", make_frame(), exp_a);

        // Packing and latency with ready tied high.
        rx_log.delete(); done_cnt = 0;
        pulse_start();
        chk("first_valid", 32'(tx_if.tx_valid), 32'd1);
        chk("first_byte", 32'(tx_if.tx_data), 32'h00);
        k = 0;
        while (!done && k < 60) begin tick(); k++; end
        chk("done_latency", 32'(k), 32'd24);
        tick();
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        compare_q("pack", rx_log, exp_a);

        // Backpressure: stall in front of byte 3, then random ready.
        rx_log.delete(); done_cnt = 0;
        pulse_start();
        tick(); tick(); tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(tx_if.tx_valid), 32'd1);
            chk("stall_byte3", 32'(tx_if.tx_data), 32'h40);
        end
        k = 0;
        while (!done && k < 300) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        ready = 1'b1;
        wait_idle("bp");
        compare_q("backpressure", rx_log, exp_a);
        chk("bp_done_count", 32'(done_cnt), 32'd1);

        // Snapshot: every input changes right after the start edge.
        rx_log.delete(); done_cnt = 0;
        set_frame_a();
        pulse_start();
        set_frame_c();
        wait_idle("snap");
        compare_q("snapshot", rx_log, exp_a);

        // Start while busy is ignored.
        rx_log.delete(); done_cnt = 0;
        set_frame_b();
        exp_b = make_frame();
        pulse_start();
        repeat (5) tick();
        set_frame_c();
        pulse_start();
        repeat (17) tick();
        pulse_start();
        wait_idle("busy_start");
        repeat (3) tick();
        compare_q("busy_start", rx_log, exp_b);
        chk("busy_start_done_count", 32'(done_cnt), 32'd1);

        // Reset mid-frame aborts cleanly, then a full frame follows.
        rx_log.delete(); done_cnt = 0;
        set_frame_a();
        pulse_start();
        k = 0;
        while (rx_log.size() < 10 && k < 40) begin tick(); k++; end
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        rx_log.delete(); done_cnt = 0;
        pulse_start();
        wait_idle("after_rst");
        compare_q("after_rst", rx_log, exp_a);
        chk("after_rst_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back: restart on the first idle cycle.
        rx_log.delete(); done_cnt = 0;
        set_frame_a();
        pulse_start();
        wait_idle("b2b_first");
        set_frame_c();
        exp_c = make_frame();
        pulse_start();
        chk("b2b_valid", 32'(tx_if.tx_valid), 32'd1);
        chk("b2b_byte0", 32'(tx_if.tx_data), 32'h5A);
        wait_idle("b2b_second");
        exp_ac = exp_a;
        foreach (exp_c[i]) exp_ac.push_back(exp_c[i]);
        compare_q("b2b", rx_log, exp_ac);
        chk("b2b_done_count", 32'(done_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_latch_dumper.md
Name: id_ex_latch_dumper

Overview:
- Debug-side reader of the ID/EX pipeline latch.
- On a start pulse from the debug unit, it snapshots every ID/EX output field into one frame, then streams the frame as bytes, MSB first, over a valid/ready byte interface to the UART transmitter.
- It sits between the ID/EX register outputs and the debug unit's TX path.
- It never writes back into the pipeline.

Parameters:
- NBITS, 32, datapath width of pc/ALU_src_A/ALU_src_B/AGU_src_addr; must be a multiple of 8.
- FRAME_BITS, 4*NBITS+64, derived; frame width (192 at default).
- FRAME_BYTES, FRAME_BITS/8, derived; bytes per dump (24 at default).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request to dump the latch
- i_pc, i_ALU_src_A, i_ALU_src_B, i_AGU_src_addr  in  NBITS each  ID/EX data fields
- i_rd, i_rt, i_rs  in  5 each  register indices
- i_addr_offset  in  26  offset/jump field
- i_flg_equal, i_flg_unsign, i_flg_branch, i_flg_jump, i_flg_reg_wr_en, i_flg_mem_wr_en, i_flg_wb_src, i_flg_ALU_src_B, i_flg_mem_op, i_flg_halt  in  1 each  control flags
- i_flg_mem_size, i_ALU_dst, i_flg_ALU_src_A  in  2 each  control fields
- i_ALU_opcode  in  4  ALU opcode
- i_AGU_opcode  in  3  AGU opcode
- i_tx_ready  in  1  UART TX can accept a byte
- o_tx_data  out  8  current byte
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state=IDLE, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0, shift register=0, byte counter=0.
- Frame layout, MSB to LSB: {pc, ALU_src_A, ALU_src_B, AGU_src_addr, ctrl64}.
- ctrl64 is {rd, rt, rs, addr_offset, equal, mem_size, unsign, ALU_dst, ALU_opcode, AGU_opcode, branch, jump, reg_wr_en, mem_wr_en, wb_src, flg_ALU_src_A, flg_ALU_src_B, mem_op, halt}, which is 41+23=64 bits. halt is bit 0.
- IDLE:
  - i_start=1 captures the packed frame into the shift register on that edge.
  - Clears the counter and goes to SEND.
  - Inputs may change afterwards; the snapshot is what gets sent.
- SEND:
  - o_tx_valid=1 and o_tx_data=shift_reg[FRAME_BITS-1 -: 8].
  - A byte transfers on an edge where o_tx_valid and i_tx_ready are both 1.
  - On transfer: shift left 8, counter+1.
  - While i_tx_ready=0, o_tx_data and o_tx_valid hold stable.
  - Transfer of byte FRAME_BYTES-1 moves to DONE, and o_tx_valid drops the next cycle.
- DONE: o_done=1 for exactly one cycle, o_tx_valid=0, then IDLE.
- o_busy=1 in SEND and DONE.
- i_start while o_busy=1 is ignored, with no queuing.
- Latency, with ready tied high and start at edge N:
  - o_tx_valid is high for cycles N+1..N+FRAME_BYTES.
  - o_done is high at N+FRAME_BYTES+1.
  - A new start is accepted from N+FRAME_BYTES+2.
- i_tx_ready asserted while not valid has no effect.
- Reset mid-frame aborts immediately to the reset values. No partial o_done is generated.
- Counter width is $clog2(FRAME_BYTES). No wrap occurs inside a frame.

Decomposition:
- Shared debug package:
  - FRAME_BITS/FRAME_BYTES functions of NBITS.
  - ctrl64 field offsets (RD_MSB=63, RT_MSB=58, RS_MSB=53, OFFS_MSB=48, FLAGS_MSB=22).
  - State encodings IDLE/SEND/DONE.
  - The same constants are reused by the host-side decoder script and by the other latch dumpers (IF/ID, EX/MEM, MEM/WB).
- No sub-module: frame packing is one concatenation, and the FSM plus shift register is a single module.

Test Plan:
- Packing with ready tied high:
  - Stimulus: pc=0x00000040, ALU_src_A=0x11111111, ALU_src_B=0x22222222, AGU_src_addr=0x33333333, rd=3, rt=2, rs=1, halt=1, all else 0, then 1-cycle start.
  - Response: 24 bytes 00 00 00 40 11 11 11 11 22 22 22 22 33 33 33 33 18 82 00 00 00 00 00 01 on consecutive cycles.
  - Then o_done for 1 cycle, then o_busy=0.
- Backpressure:
  - Stimulus: same frame, i_tx_ready low for 5 cycles before byte 3 and randomly toggled elsewhere.
  - Response: byte 3 holds 0x40 with valid high throughout the stall, and there are no duplicated or dropped bytes.
- Snapshot: change every input the cycle after start → transmitted bytes still equal the values captured at start.
- Start while busy: pulse i_start at bytes 5 and 23 → ignored, exactly one frame sent, one o_done.
- Reset mid-frame: assert i_rst after byte 10 → next cycle valid=0, busy=0, done=0. A following start sends the full 24-byte frame from byte 0.
- Back-to-back: start again on the first cycle after busy falls → second frame begins the next cycle with correct contents.
